// File: rtl/spin_field_reader.sv
// Computes the next neuron spin from a snapshot of the spin history and a weight table,
// then presents it on xin with a one-cycle update_clk strobe.
module spin_field_reader #(
  parameter int N_TAPS    = 20,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 16,
  parameter logic signed [ACC_WIDTH-1:0] THRESH = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*N_TAPS-1:0]   xalt_packed,
  input  logic                  w_we,
  input  logic [4:0]            w_addr,
  input  logic [W_WIDTH-1:0]    w_data,
  output logic [1:0]            xin,
  output logic                  update_clk,
  output logic                  busy,
  output logic [ACC_WIDTH-1:0]  field
);

  // state  | meaning
  // IDLE   | waiting for start
  // SNAP   | capture xalt_packed, clear accumulator
  // MAC    | one weighted tap per cycle
  // DECIDE | publish field, threshold into xin
  // PULSE  | arm the update_clk strobe
  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_MAC, S_DECIDE, S_PULSE} state_t;

  localparam int SW = ACC_WIDTH + 1;
  localparam logic [4:0] LAST_TAP = 5'(N_TAPS - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                       state;
  logic signed [W_WIDTH-1:0]    w_mem [N_TAPS];
  logic [2*N_TAPS-1:0]          snap;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [4:0]                   tap;
  logic [1:0]                   spin;
  logic signed [SW-1:0]         w_ext;
  logic signed [SW-1:0]         term;
  logic signed [SW-1:0]         sum;
  logic signed [ACC_WIDTH-1:0]  acc_next;

  // One extra bit of headroom makes overflow visible in the top two bits of sum.
  always_comb begin
    spin  = snap[{tap, 1'b0} +: 2];
    w_ext = SW'(w_mem[tap]);
    term  = '0;
    case (spin)
      2'b01:   term = w_ext;
      2'b11:   term = -w_ext;
      default: term = '0;
    endcase
    sum = SW'(acc) + term;
    case (sum[SW-1 -: 2])
      2'b01:   acc_next = ACC_MAX;
      2'b10:   acc_next = ACC_MIN;
      default: acc_next = sum[ACC_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      xin        <= 2'b01;
      update_clk <= 1'b0;
      busy       <= 1'b0;
      field      <= '0;
      acc        <= '0;
      tap        <= '0;
      snap       <= '0;
      for (int i = 0; i < N_TAPS; i++) w_mem[i] <= '0;
    end else begin
      update_clk <= 1'b0;
      if (w_we && !busy && (int'(w_addr) < N_TAPS)) w_mem[w_addr] <= w_data;
      case (state)
        S_IDLE: begin
          busy <= start;
          if (start) state <= S_SNAP;
        end
        S_SNAP: begin
          snap  <= xalt_packed;
          acc   <= '0;
          tap   <= '0;
          state <= S_MAC;
        end
        S_MAC: begin
          acc <= acc_next;
          tap <= tap + 5'd1;
          if (tap == LAST_TAP) state <= S_DECIDE;
        end
        S_DECIDE: begin
          field <= acc;
          if (acc > THRESH)      xin <= 2'b01;
          else if (acc < THRESH) xin <= 2'b11;
          state <= S_PULSE;
        end
        S_PULSE: begin
          update_clk <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
